// File: rtl/stream_to_axi_pkg.sv
// Shared types and constants for the stream-to-AXI record replayer.
// Header layout: addr in [ADDR_W-1:0], len and is_write placed directly above it.
package stream_to_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StAr,
        StR,
        StDrain
    } state_e;

    // Header field offsets, relative to the top of the address field.
    localparam int unsigned HDR_LEN_REL = 0;
    localparam int unsigned HDR_LEN_W   = 8;
    localparam int unsigned HDR_WR_REL  = 8;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic logic [2:0] axi_size(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/stream_to_axi.sv
// Replays packed stream records (header + write data) as single AXI4 bursts.
// Define STREAM_TO_AXI_ERRCNT_EN to add the saturating per-transaction error counter.
module stream_to_axi
    import stream_to_axi_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  busy,
    output logic                  proto_err,
    output logic                  resp_err
`ifdef STREAM_TO_AXI_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]      err_count
`endif
);

    if (DATA_W < ADDR_W + 9 || CNT_W == 0) begin : g_bad_param
        $error("stream_to_axi: DATA_W must be >= ADDR_W+9 and CNT_W nonzero");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              hdr_last_q, hdr_last_d;
    logic              pad_q, pad_d;
    logic              drain_q, drain_d;
    logic              proto_err_q, resp_err_q;
    logic              proto_set, resp_set;

    logic [ADDR_W-1:0] hdr_addr;
    logic [7:0]        hdr_len;
    logic              hdr_wr;
    logic              unused_rdata;

    assign hdr_addr     = s_axis_tdata[ADDR_W-1:0];
    assign hdr_len      = s_axis_tdata[ADDR_W+HDR_LEN_REL +: HDR_LEN_W];
    assign hdr_wr       = s_axis_tdata[ADDR_W+HDR_WR_REL];
    assign unused_rdata = ^m_axi_rdata;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = axi_size(DATA_W);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = axi_size(DATA_W);
    assign m_axi_arburst = BURST_INCR;

    assign busy      = (state_q != StIdle);
    assign proto_err = proto_err_q;
    assign resp_err  = resp_err_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        hdr_last_d    = hdr_last_q;
        pad_d         = pad_q;
        drain_d       = drain_q;
        proto_set     = 1'b0;
        resp_set      = 1'b0;
        s_axis_tready = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ready is forced low while reset is held so no beat is taken mid-reset.
                s_axis_tready = ~areset;
                if (s_axis_tvalid && s_axis_tready) begin
                    addr_d     = hdr_addr;
                    len_d      = hdr_len;
                    hdr_last_d = s_axis_tlast;
                    drain_d    = 1'b0;
                    pad_d      = hdr_wr & s_axis_tlast;
                    proto_set  = hdr_wr & s_axis_tlast;
                    state_d    = hdr_wr ? StAw : StAr;
                end
            end
            StAw: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    cnt_d   = '0;
                    state_d = StW;
                end
            end
            StW: begin
                m_axi_wlast = (cnt_q == len_q);
                if (pad_q) begin
                    m_axi_wvalid = 1'b1;
                end else begin
                    m_axi_wvalid  = s_axis_tvalid;
                    s_axis_tready = m_axi_wready;
                    m_axi_wdata   = s_axis_tdata;
                    m_axi_wstrb   = '1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (m_axi_wlast) begin
                        state_d = StB;
                        if (!pad_q && !s_axis_tlast) begin
                            proto_set = 1'b1;
                            drain_d   = 1'b1;
                        end
                    end else if (!pad_q && s_axis_tlast) begin
                        proto_set = 1'b1;
                        pad_d     = 1'b1;
                    end
                end
            end
            StB: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_set = (m_axi_bresp != RESP_OKAY);
                    state_d  = drain_q ? StDrain : StIdle;
                end
            end
            StAr: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    resp_set = (m_axi_rresp != RESP_OKAY);
                    if (m_axi_rlast) begin
                        proto_set = ~hdr_last_q;
                        state_d   = hdr_last_q ? StIdle : StDrain;
                    end
                end
            end
            StDrain: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            hdr_last_q  <= 1'b0;
            pad_q       <= 1'b0;
            drain_q     <= 1'b0;
            proto_err_q <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hdr_last_q  <= hdr_last_d;
            pad_q       <= pad_d;
            drain_q     <= drain_d;
            proto_err_q <= proto_err_q | proto_set;
            resp_err_q  <= resp_err_q | resp_set;
        end
    end

`ifdef STREAM_TO_AXI_ERRCNT_EN
    logic             txn_err_q, txn_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Errors are collected per transaction and counted once on the return to idle.
    always_comb begin
        txn_err_d = txn_err_q | proto_set | resp_set;
        err_cnt_d = err_cnt_q;
        if (state_q == StIdle) begin
            txn_err_d = proto_set;
        end else if (state_d == StIdle) begin
            txn_err_d = 1'b0;
            if ((txn_err_q | proto_set | resp_set) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            txn_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            txn_err_q <= txn_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_stream_to_axi.sv
// Randomized scoreboard bench for stream_to_axi with a record-level reference model.
module tb_stream_to_axi;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 16;

    logic aclk = 1'b0;
    logic areset = 1'b0;

    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = '0;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic          busy;
    logic          proto_err;
    logic          resp_err;
`ifdef STREAM_TO_AXI_ERRCNT_EN
    logic [CW-1:0] err_count;
`endif

    stream_to_axi #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .busy          (busy),
        .proto_err     (proto_err),
        .resp_err      (resp_err)
`ifdef STREAM_TO_AXI_ERRCNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } wbeat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } req_t;

    beat_t      stim_q[$];
    wbeat_t     exp_w_q[$];
    req_t       exp_aw_q[$];
    req_t       exp_ar_q[$];
    logic [1:0] resp_q[$];
    int         r_len_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_proto = 1'b0;
    logic m_resp = 1'b0;
    int   m_cnt = 0;
    int   b_pend = 0;
    int   r_left = 0;
    int   w_hs = 0;
    logic b_done = 1'b0;
    logic r_done = 1'b0;
    logic abort = 1'b0;

    initial forever #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes are judged at negedge, where both sides are stable.
    initial forever begin
        req_t   r;
        wbeat_t w;
        @(negedge aclk);
        b_done = !areset && m_axi_bvalid && m_axi_bready;
        r_done = !areset && m_axi_rvalid && m_axi_rready;
        if (!areset) begin
            if (m_axi_awvalid && m_axi_awready) begin
                check("aw_expected", 64'(exp_aw_q.size() > 0), 64'd1);
                if (exp_aw_q.size() > 0) begin
                    r = exp_aw_q.pop_front();
                    check("awaddr", 64'(m_axi_awaddr), 64'(r.addr));
                    check("awlen", 64'(m_axi_awlen), 64'(r.len));
                    check("awsize", 64'(m_axi_awsize), 64'd3);
                    check("awburst", 64'(m_axi_awburst), 64'd1);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs++;
                check("w_expected", 64'(exp_w_q.size() > 0), 64'd1);
                if (exp_w_q.size() > 0) begin
                    w = exp_w_q.pop_front();
                    check("wdata", m_axi_wdata, w.data);
                    check("wstrb", 64'(m_axi_wstrb), 64'(w.strb));
                    check("wlast", 64'(m_axi_wlast), 64'(w.last));
                end
                if (m_axi_wlast) b_pend++;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                check("ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
                if (exp_ar_q.size() > 0) begin
                    r = exp_ar_q.pop_front();
                    check("araddr", 64'(m_axi_araddr), 64'(r.addr));
                    check("arlen", 64'(m_axi_arlen), 64'(r.len));
                    check("arsize", 64'(m_axi_arsize), 64'd3);
                    check("arburst", 64'(m_axi_arburst), 64'd1);
                end
                r_len_q.push_back(int'(m_axi_arlen) + 1);
            end
        end
    end

    // Slave: random readies, B after each wlast, R bursts after each AR.
    initial forever begin
        @(posedge aclk);
        #1;
        if (areset) begin
            m_axi_bvalid = 1'b0;
            m_axi_rvalid = 1'b0;
            b_pend = 0;
            r_left = 0;
            r_len_q.delete();
            continue;
        end
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_wready  = ($urandom_range(0, 3) != 0);
        m_axi_arready = 1'($urandom_range(0, 1));
        if (m_axi_bvalid && b_done) begin
            m_axi_bvalid = 1'b0;
            b_pend--;
            if (resp_q.size() > 0) void'(resp_q.pop_front());
        end else if (!m_axi_bvalid && b_pend > 0 && $urandom_range(0, 1) == 1) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (resp_q.size() > 0) ? resp_q[0] : 2'b00;
        end
        if (m_axi_rvalid && r_done) begin
            m_axi_rvalid = 1'b0;
            r_left--;
            if (r_left == 0 && resp_q.size() > 0) void'(resp_q.pop_front());
        end
        if (!m_axi_rvalid) begin
            if (r_left == 0 && r_len_q.size() > 0) r_left = r_len_q.pop_front();
            if (r_left > 0 && $urandom_range(0, 2) != 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rlast  = (r_left == 1);
                m_axi_rresp  = (resp_q.size() > 0) ? resp_q[0] : 2'b00;
                m_axi_rdata  = {$urandom, $urandom};
            end
        end
    end

    // Reference model: derives stream beats and expected AXI traffic from one record.
    task automatic build_record(input logic wr, input logic [AW-1:0] addr, input int len,
                                input logic hl, input int n, input logic [1:0] resp);
        logic [DW-1:0] hdr;
        logic [DW-1:0] d[$];
        logic          perr;
        beat_t         b;
        wbeat_t        w;
        req_t          r;
        hdr = {$urandom, $urandom};
        hdr[AW-1:0] = addr;
        hdr[AW +: 8] = 8'(len);
        hdr[AW+8] = wr;
        b.data = hdr;
        b.last = hl;
        stim_q.push_back(b);
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.last = (i == n - 1);
            d.push_back(b.data);
            stim_q.push_back(b);
        end
        r.addr = addr;
        r.len  = 8'(len);
        if (wr) begin
            exp_aw_q.push_back(r);
            for (int i = 0; i <= len; i++) begin
                if (!hl && i < n) begin
                    w.data = d[i];
                    w.strb = '1;
                end else begin
                    w.data = '0;
                    w.strb = '0;
                end
                w.last = (i == len);
                exp_w_q.push_back(w);
            end
            perr = hl || (n != len + 1);
        end else begin
            exp_ar_q.push_back(r);
            perr = !hl;
        end
        resp_q.push_back(resp);
        m_proto = m_proto | perr;
        m_resp  = m_resp | (resp != 2'b00);
        if ((perr || resp != 2'b00) && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic drive_stim();
        int   cyc = 0;
        logic hs;
        while (stim_q.size() > 0 && !abort && cyc < 5000) begin
            if (!s_axis_tvalid && $urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
                cyc++;
                continue;
            end
            s_axis_tdata  = stim_q[0].data;
            s_axis_tlast  = stim_q[0].last;
            s_axis_tvalid = 1'b1;
            @(negedge aclk);
            hs = s_axis_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (hs) begin
                void'(stim_q.pop_front());
                s_axis_tvalid = 1'b0;
            end
        end
        s_axis_tvalid = 1'b0;
        check("stim_done", 64'(cyc < 5000), 64'd1);
    endtask

    task automatic wait_idle_check();
        int k = 0;
        while ((busy || exp_w_q.size() > 0 || exp_aw_q.size() > 0 || exp_ar_q.size() > 0 ||
                resp_q.size() > 0) && k < 3000) begin
            @(posedge aclk);
            #1;
            k++;
        end
        check("idle_reached", 64'(k < 3000), 64'd1);
        @(negedge aclk);
        check("busy_idle", 64'(busy), 64'd0);
        check("proto_err", 64'(proto_err), 64'(m_proto));
        check("resp_err", 64'(resp_err), 64'(m_resp));
`ifdef STREAM_TO_AXI_ERRCNT_EN
        check("err_count", 64'(err_count), 64'(m_cnt));
`endif
        @(posedge aclk);
        #1;
    endtask

    task automatic do_record(input logic wr, input logic [AW-1:0] addr, input int len,
                             input logic hl, input int n, input logic [1:0] resp);
        build_record(wr, addr, len, hl, n, resp);
        drive_stim();
        wait_idle_check();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
        check({tag, "_wvalid"}, 64'(m_axi_wvalid), 64'd0);
        check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        check({tag, "_bready"}, 64'(m_axi_bready), 64'd0);
        check({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
        check({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_proto"}, 64'(proto_err), 64'd0);
        check({tag, "_resp"}, 64'(resp_err), 64'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        m_proto = 1'b0;
        m_resp  = 1'b0;
        m_cnt   = 0;
        areset  = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int            base;
        logic          wr, hl;
        int            len, n, sel;
        logic [1:0]    resp;
        #1 areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_quiet("rst");
        check("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        check("rst_awlen", 64'(m_axi_awlen), 64'd0);
`ifdef STREAM_TO_AXI_ERRCNT_EN
        check("rst_err_count", 64'(err_count), 64'd0);
`endif
        areset = 1'b0;
        @(posedge aclk);
        #1;

        do_record(1'b1, 32'h1000, 3, 1'b0, 4, 2'b00);
        do_record(1'b0, 32'h2000, 7, 1'b1, 0, 2'b00);
        do_record(1'b1, 32'h1100, 3, 1'b0, 2, 2'b00);
        do_record(1'b1, 32'h1200, 0, 1'b0, 3, 2'b00);
        do_record(1'b1, 32'h1300, 2, 1'b0, 3, 2'b00);
        do_record(1'b0, 32'h2100, 0, 1'b1, 0, 2'b10);

        // Reset while the second beat of a len=7 write is on the W channel.
        build_record(1'b1, 32'h3000, 7, 1'b0, 8, 2'b00);
        base = w_hs;
        fork
            drive_stim();
            begin
                int k = 0;
                while (w_hs < base + 1 && k < 2000) begin
                    @(posedge aclk);
                    k++;
                end
                check("midrst_reached", 64'(k < 2000), 64'd1);
                #3 areset = 1'b1;
                #1 check_quiet("midrst");
                abort = 1'b1;
            end
        join
        exp_w_q.delete();
        exp_aw_q.delete();
        resp_q.delete();
        stim_q.delete();
        m_proto = 1'b0;
        m_resp  = 1'b0;
        m_cnt   = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        abort  = 1'b0;
        @(posedge aclk);
        #1;
        do_record(1'b1, 32'h4000, 5, 1'b0, 6, 2'b00);

        for (int i = 0; i < 30; i++) begin
            if (i % 8 == 7) do_reset();
            wr   = 1'($urandom_range(0, 1));
            len  = $urandom_range(0, 9);
            sel  = $urandom_range(0, 9);
            resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (wr) begin
                hl = (sel == 0);
                if (sel == 0) n = 0;
                else if (sel < 3) n = $urandom_range(1, len + 4);
                else n = len + 1;
            end else begin
                hl = (sel >= 2);
                n  = hl ? 0 : $urandom_range(1, 3);
            end
            do_record(wr, $urandom, len, hl, n, resp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_to_axi.md
Name: stream_to_axi

Overview:
- Reverse path of the AXI-to-stream bridge.
- Consumes an AXI4-Stream of packed transaction records (header beat, then write-data beats) and replays each record as one AXI4 master burst, read or write.
- Sits between the Ethernet-side stream fabric and an AXI slave, e.g. DDR or a register bank.
- Read data and write responses are consumed and checked; only error status is reported.

Parameters:
- DATA_W, 64: width of TDATA, WDATA and RDATA. Must satisfy DATA_W >= ADDR_W+9.
- ADDR_W, 32: AXI address width.
- CNT_W, 16: width of the error counter (optional feature only).

Ports:
- aclk  in  1  sole clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_W  stream record beat.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tlast  in  1  end of record.
- m_axi_awaddr  out  ADDR_W / m_axi_awlen  out  8 / m_axi_awsize  out  3 / m_axi_awburst  out  2 / m_axi_awvalid  out  1 / m_axi_awready  in  1: AW channel.
- m_axi_wdata  out  DATA_W / m_axi_wstrb  out  DATA_W/8 / m_axi_wlast  out  1 / m_axi_wvalid  out  1 / m_axi_wready  in  1: W channel.
- m_axi_bresp  in  2 / m_axi_bvalid  in  1 / m_axi_bready  out  1: B channel.
- m_axi_araddr  out  ADDR_W / m_axi_arlen  out  8 / m_axi_arsize  out  3 / m_axi_arburst  out  2 / m_axi_arvalid  out  1 / m_axi_arready  in  1: AR channel.
- m_axi_rdata  in  DATA_W / m_axi_rresp  in  2 / m_axi_rlast  in  1 / m_axi_rvalid  in  1 / m_axi_rready  out  1: R channel.
- busy  out  1: high whenever the FSM is not IDLE.
- proto_err  out  1: sticky; set on any record framing violation.
- resp_err  out  1: sticky; set on any BRESP or RRESP != OKAY.

Behaviour:
- Reset: areset is asynchronous, active-high. While asserted:
  - all valid/ready outputs = 0, FSM = IDLE, busy = 0, proto_err = 0, resp_err = 0;
  - registered address/len fields = 0.
- Header beat layout: [ADDR_W-1:0] = addr; [ADDR_W+7:ADDR_W] = len (beats-1); [ADDR_W+8] = is_write; remaining bits ignored.
- Fixed AXI fields: awsize/arsize = log2(DATA_W/8); awburst/arburst = INCR.
- FSM states and transitions:
  - IDLE: s_axis_tready = 1. On a header handshake, register the fields and hdr_last = tlast. Go to AW if is_write, else AR.
  - AW: awvalid = 1, held stable until awready. Then go to W, with beat counter = 0.
  - W, stream-fed:
    - wvalid = tvalid, s_axis_tready = wready (combinational), wdata = tdata, wstrb all ones.
    - wlast = (counter == len).
    - Counter increments on each W handshake.
  - W, pad mode: entered if tlast arrives before counter == len, or if hdr_last = 1 on a write header.
    - Set proto_err.
    - Remaining beats are driven internally: wvalid = 1, wstrb = 0, wdata = 0, s_axis_tready = 0.
  - W exit: on the wlast handshake, go to B.
    - If the stream was feeding and the final beat's tlast = 0, set proto_err and mark drain_pending.
  - B: bready = 1. On bvalid, capture resp_err if bresp != 0. Go to DRAIN if drain_pending, else IDLE.
  - AR: arvalid = 1 until arready, then go to R.
  - R: rready = 1. Each beat ORs rresp != 0 into resp_err.
    - On rlast: go to DRAIN if hdr_last = 0 (read header must carry tlast), and set proto_err in that case; else go to IDLE.
  - DRAIN: s_axis_tready = 1, beats discarded. The beat with tlast returns the FSM to IDLE.
- Ordering: one outstanding transaction only. No new header is accepted until IDLE.
- Latency: header-to-awvalid/arvalid is 1 cycle. The W path adds no register stage.
- len = 0 gives a single beat with wlast = 1 on the first beat.
- Address is passed unmodified. 4 KB boundary compliance is the producer's responsibility and is not checked.
- Reset mid-burst: all state clears immediately. AXI outputs drop without completing; the system resets the slave concurrently.
- Simultaneous events: tlast on the beat where counter == len is a legal end. Early tlast takes priority on the same beat, i.e. the beat is sent and pad starts on the next beat.

Optional Feature:
- Macro: STREAM_TO_AXI_ERRCNT_EN.
- Defined: adds output err_count [CNT_W-1:0], reset 0. It increments once per completed transaction that raised proto_err or resp_err during that transaction. It saturates at all ones.
- Undefined: the port and counter are absent; sticky flags only.

Decomposition:
- Package stream_to_axi_pkg holds:
  - state enum (IDLE, AW, W, B, AR, R, DRAIN);
  - header field offset localparams;
  - AXI constants RESP_OKAY and BURST_INCR;
  - a function that computes the size encoding from DATA_W.
- No sub-module. The header unpack is plain combinational logic inside the block.

Test Plan:
- Write header addr=0x1000, len=3, then 4 data beats with tlast on the 4th, BRESP=OKAY -> awaddr=0x1000, awlen=3; 4 W beats, wlast on beat 4; proto_err=0, busy returns to 0.
- Read header addr=0x2000, len=7, tlast=1, RRESP=OKAY on all 8 beats -> araddr=0x2000, arlen=7; 8 R handshakes; FSM returns to IDLE.
- Write len=3 with tlast on beat 2 -> beats 3 and 4 carry wstrb=0; proto_err=1; next record still executes normally.
- Write len=0 followed by 2 extra beats, tlast on the last -> 1 W beat sent; 2 beats drained after B; proto_err=1.
- Read len=0 with RRESP=SLVERR -> resp_err=1; err_count=1 when STREAM_TO_AXI_ERRCNT_EN is defined.
- Assert areset during W beat 2 of len=7 -> all valids 0 asynchronously; after release, a fresh write header completes correctly.
